spi_cmd_rx: RTL and testbench
=============================

# spi_cmd_rx

Receives MCU command frames over a 4-wire SPI slave link, oversampled in the 48 MHz system clock. It validates each frame and drives the real-time command register's write port: the command fields plus a one-cycle SPI_WR strobe. It also drives the synchroniser's system-time preset: TIME_INIT, plus a SYS_TIME_UPDATE level held until SYS_TIME_UPDATE_OK. It is the transmitting end of the interface that the command register consumes, and replaces the hand-driven stimulus at that port.

## Interface
- SCK_DIV_MIN, 8: minimum CLK cycles per SCK period supported (documentation/assertion only).
- CLK  in  1  48 MHz system clock.
- rst_n  in  1  synchronous active-low reset.
- SCK, CS_n, MOSI  in  1 each  SPI mode 0, MSB first, asynchronous to CLK.
- SYS_TIME_UPDATE_OK  in  1  one-cycle pulse: time preset was applied at the T1hz mark.
- FREQ, FREQ_STEP  out  48 each  DDS start frequency / step.
- FREQ_RATE  out  32  step rate.
- TIME_START  out  64  start time.
- N_impulse  out  16  number of work intervals.
- TYPE_impulse  out  2  burst type.
- Interval_Ti, Interval_Tp, Tblank1, Tblank2  out  32 each  interval lengths in CLK ticks.
- SPI_WR  out  1  one-cycle strobe: command fields are valid.
- TIME_INIT  out  64  system time preset value.
- SYS_TIME_UPDATE  out  1  level: a time preset is pending.
- FRAME_ERR  out  1  one-cycle pulse: a frame was rejected.
- ERR_CNT  out  8  saturating count of rejected frames.

## Operation
- Input sync: SCK, CS_n and MOSI each pass through 2 flops. A third flop on SCK and CS_n provides edge detection. MOSI is sampled on a synced SCK rising edge while synced CS_n = 0.
- Byte assembly: 3-bit bit counter and 8-bit shift register. A byte completes on the 8th rising edge. The bit counter clears on CS_n falling edge.
- States: IDLE, HDR, PAYLOAD, CHK, DONE, DROP.
  - IDLE -> HDR on CS_n fall.
  - HDR: first byte selects the frame type. 0xA1 is a command frame (43 payload bytes). 0xA2 is a time frame (8 payload bytes). Any other value -> DROP.
  - PAYLOAD: 6-bit byte counter counts up to the payload length, then -> CHK.
  - CHK: one byte is received, then -> DONE. Any further byte in DONE -> DROP.
- Command payload order is big-endian per field: FREQ(6), FREQ_STEP(6), FREQ_RATE(4), TIME_START(8), N_impulse(2), TYPE byte(1, bits[1:0] used, bits[7:2] ignored), Interval_Ti(4), Interval_Tp(4), Tblank1(4), Tblank2(4).
- Time payload: TIME_INIT(8).
- Payload assembles into a shadow register. Outputs change only on commit.
- Checksum: 8-bit sum mod 256 of the header byte and all payload bytes. It must equal the checksum byte.
- On CS_n rise:
  - Frame is valid when state = DONE, the bit counter = 0 and the checksum matches. A valid frame commits.
  - Any other state, a partial byte, or a bad checksum rejects the frame: FRAME_ERR pulses and ERR_CNT increments, saturating at 255.
  - A CS_n rise in IDLE is ignored, with no error.
  - State returns to IDLE.
- Commit of a command frame copies the shadow to all command outputs and pulses SPI_WR.
- Commit of a time frame copies the shadow to TIME_INIT and sets SYS_TIME_UPDATE.
- SYS_TIME_UPDATE clears on SYS_TIME_UPDATE_OK. If a time-frame commit coincides with the OK pulse, SYS_TIME_UPDATE stays 1 with the new TIME_INIT. A new time frame while a preset is pending overwrites TIME_INIT and keeps the level high.
- DROP ignores all bytes until CS_n rises.

## Timing
- Reset values are 0 for every output, for state = IDLE, and for all counters and shadow registers. A reset mid-frame discards the frame. If CS_n is still low when reset releases, the block waits for a fresh CS_n fall.
- Commit latency: the CS_n rise is sampled at CLK edge k and detected at k+3. Outputs update and SPI_WR/FRAME_ERR assert at edge k+4. SPI_WR is high for exactly 1 cycle, and the fields are stable in that cycle and afterwards until the next commit.
- SYS_TIME_UPDATE rises at k+4. It falls at the edge after SYS_TIME_UPDATE_OK is sampled high.
- SCK high and low phases must each be ≥ 4 CLK cycles (SCK ≤ 6 MHz). MOSI must be stable ≥ 3 CLK cycles before and after each SCK rise.
- CS_n high time between frames is ≥ 4 CLK cycles. A frame shorter than this separation is undefined.

## Test plan
- Command frame A1, payload FREQ=0x001000000000, FREQ_STEP=0x000000100000, FREQ_RATE=0x100, TIME_START=0x12C0, N=2, TYPE=1, Ti=Tp=0x1800, Tblank1=Tblank2=0x180, correct checksum, SCK=6 MHz -> exactly one SPI_WR pulse 4 cycles after the CS_n rise, all fields equal the sent values, FRAME_ERR=0.
- Same frame with checksum+1 -> FRAME_ERR pulse, ERR_CNT=1, outputs still hold the previous values, no SPI_WR.
- Time frame A2, TIME_INIT=0x0000000000000000 after a prior preset of 0x55 -> TIME_INIT=0 and SYS_TIME_UPDATE=1. An OK pulse 100 cycles later clears it the next cycle. A commit coincident with OK keeps it at 1.
- Header 0x33, CS_n raised after 5 bits of byte 3, and a 46-byte A1 frame -> three FRAME_ERR pulses, ERR_CNT=3, no SPI_WR.
- rst_n low for 1 cycle during byte 20 of an A1 frame, CS_n held low to frame end -> no commit, no error. The next clean frame commits normally.
- 260 bad frames -> ERR_CNT saturates at 255.

Source files
------------

// File: rtl/spi_cmd_rx_if.sv
// Write port of the real-time command register and system-time preset handshake.
// The master end (spi_cmd_rx) drives the fields; the consumer answers SYS_TIME_UPDATE_OK.
interface spi_cmd_rx_if;
    logic [47:0] FREQ;
    logic [47:0] FREQ_STEP;
    logic [31:0] FREQ_RATE;
    logic [63:0] TIME_START;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic [31:0] Interval_Ti;
    logic [31:0] Interval_Tp;
    logic [31:0] Tblank1;
    logic [31:0] Tblank2;
    logic        SPI_WR;
    logic [63:0] TIME_INIT;
    logic        SYS_TIME_UPDATE;
    logic        SYS_TIME_UPDATE_OK;

    modport master (
        output FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
               Interval_Ti, Interval_Tp, Tblank1, Tblank2, SPI_WR,
               TIME_INIT, SYS_TIME_UPDATE,
        input  SYS_TIME_UPDATE_OK
    );

    modport slave (
        input  FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
               Interval_Ti, Interval_Tp, Tblank1, Tblank2, SPI_WR,
               TIME_INIT, SYS_TIME_UPDATE,
        output SYS_TIME_UPDATE_OK
    );
endinterface

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave that receives, validates and commits MCU command / time-preset frames,
// oversampling SCK, CS_n and MOSI in the system clock.
module spi_cmd_rx #(
    parameter int unsigned SCK_DIV_MIN = 8
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              SCK,
    input  logic              CS_n,
    input  logic              MOSI,
    spi_cmd_rx_if.master      cmd,
    output logic              FRAME_ERR,
    output logic [7:0]        ERR_CNT
);

    localparam logic [7:0] CMD_HDR   = 8'hA1;
    localparam logic [7:0] TIME_HDR  = 8'hA2;
    localparam logic [5:0] CMD_LAST  = 6'd42;
    localparam logic [5:0] TIME_LAST = 6'd7;
    localparam int         SHADOW_W  = 344;

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CHK, DONE, DROP} state_t;

    logic [2:0] sck_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;

    // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of block order.
    // Synchronisers clear to 0 so a CS_n still low after reset never looks like a fresh fall.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[1:0], SCK};
            cs_sync   <= {cs_sync[1:0], CS_n};
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    logic sck_rise, sck_edge, cs_fall, cs_rise, cs_low;
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_edge = sck_sync[1] ^ sck_sync[2];
    assign cs_fall  = ~cs_sync[1] & cs_sync[2];
    assign cs_rise  = cs_sync[1] & ~cs_sync[2];
    assign cs_low   = ~cs_sync[1];

    logic [2:0] bit_cnt;
    logic [7:0] rx_byte;
    logic       byte_done;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            rx_byte   <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_fall) begin
                bit_cnt <= '0;
            end else if (sck_rise && cs_low) begin
                rx_byte <= {rx_byte[6:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end
        end
    end

    state_t                state;
    logic [5:0]            byte_cnt;
    logic                  is_time;
    logic [7:0]            sum;
    logic                  chk_ok;
    logic [SHADOW_W-1:0]   shadow;
    logic                  cs_rise_q;
    logic                  commit_cmd;
    logic                  commit_time;
    logic                  reject;
    logic [5:0]            payload_last;

    assign payload_last = is_time ? TIME_LAST : CMD_LAST;

    // Frame end is resolved one cycle after the CS_n rise is seen so outputs land at k+4.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            is_time     <= 1'b0;
            sum         <= '0;
            chk_ok      <= 1'b0;
            shadow      <= '0;
            cs_rise_q   <= 1'b0;
            commit_cmd  <= 1'b0;
            commit_time <= 1'b0;
            reject      <= 1'b0;
        end else begin
            cs_rise_q   <= cs_rise;
            commit_cmd  <= 1'b0;
            commit_time <= 1'b0;
            reject      <= 1'b0;
            if (cs_rise_q) begin
                if (state != IDLE) begin
                    if (state == DONE && bit_cnt == 3'd0 && chk_ok) begin
                        commit_cmd  <= ~is_time;
                        commit_time <= is_time;
                    end else begin
                        reject <= 1'b1;
                    end
                end
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state    <= HDR;
                            byte_cnt <= '0;
                            chk_ok   <= 1'b0;
                        end
                    end
                    HDR: begin
                        if (byte_done) begin
                            sum      <= rx_byte;
                            byte_cnt <= '0;
                            case (rx_byte)
                                CMD_HDR: begin
                                    is_time <= 1'b0;
                                    state   <= PAYLOAD;
                                end
                                TIME_HDR: begin
                                    is_time <= 1'b1;
                                    state   <= PAYLOAD;
                                end
                                default: state <= DROP;
                            endcase
                        end
                    end
                    PAYLOAD: begin
                        if (byte_done) begin
                            shadow   <= {shadow[SHADOW_W-9:0], rx_byte};
                            sum      <= sum + rx_byte;
                            byte_cnt <= byte_cnt + 6'd1;
                            if (byte_cnt == payload_last) state <= CHK;
                        end
                    end
                    CHK: begin
                        if (byte_done) begin
                            chk_ok <= (rx_byte == sum);
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        if (byte_done) state <= DROP;
                    end
                    DROP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            cmd.FREQ            <= '0;
            cmd.FREQ_STEP       <= '0;
            cmd.FREQ_RATE       <= '0;
            cmd.TIME_START      <= '0;
            cmd.N_impulse       <= '0;
            cmd.TYPE_impulse    <= '0;
            cmd.Interval_Ti     <= '0;
            cmd.Interval_Tp     <= '0;
            cmd.Tblank1         <= '0;
            cmd.Tblank2         <= '0;
            cmd.SPI_WR          <= 1'b0;
            cmd.TIME_INIT       <= '0;
            cmd.SYS_TIME_UPDATE <= 1'b0;
            FRAME_ERR           <= 1'b0;
            ERR_CNT             <= '0;
        end else begin
            cmd.SPI_WR <= commit_cmd;
            FRAME_ERR  <= reject;
            if (reject && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
            if (commit_cmd) begin
                cmd.FREQ         <= shadow[343:296];
                cmd.FREQ_STEP    <= shadow[295:248];
                cmd.FREQ_RATE    <= shadow[247:216];
                cmd.TIME_START   <= shadow[215:152];
                cmd.N_impulse    <= shadow[151:136];
                cmd.TYPE_impulse <= shadow[129:128];
                cmd.Interval_Ti  <= shadow[127:96];
                cmd.Interval_Tp  <= shadow[95:64];
                cmd.Tblank1      <= shadow[63:32];
                cmd.Tblank2      <= shadow[31:0];
            end
            // A fresh preset wins over a coincident acknowledge of the previous one.
            if (commit_time) begin
                cmd.TIME_INIT       <= shadow[63:0];
                cmd.SYS_TIME_UPDATE <= 1'b1;
            end else if (cmd.SYS_TIME_UPDATE_OK) begin
                cmd.SYS_TIME_UPDATE <= 1'b0;
            end
        end
    end

    // SCK phase monitor: every synced SCK level must persist for at least half the minimum divider.
    logic [3:0] phase_len;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            phase_len <= '1;
        end else begin
            if (sck_edge) begin
                assert (phase_len >= 4'(SCK_DIV_MIN / 2));
                phase_len <= 4'd1;
            end else if (phase_len != '1) begin
                phase_len <= phase_len + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Randomised frame-level bench for spi_cmd_rx, checked against a byte-queue reference model.
module tb_spi_cmd_rx;

    typedef enum int {K_BAD, K_CMD, K_TIME, K_NONE} kind_t;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       SCK;
    logic       CS_n;
    logic       MOSI;
    logic       FRAME_ERR;
    logic [7:0] ERR_CNT;

    spi_cmd_rx_if cmd_if();

    spi_cmd_rx dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .SCK       (SCK),
        .CS_n      (CS_n),
        .MOSI      (MOSI),
        .cmd       (cmd_if),
        .FRAME_ERR (FRAME_ERR),
        .ERR_CNT   (ERR_CNT)
    );

    always #10 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  frame[$];

    logic [47:0] m_freq, m_step;
    logic [31:0] m_rate, m_ti, m_tp, m_tb1, m_tb2;
    logic [63:0] m_ts, m_time;
    logic [15:0] m_n;
    logic [1:0]  m_type;
    logic        m_upd;
    int          m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_freq = '0; m_step = '0; m_rate = '0; m_ts = '0; m_n = '0; m_type = '0;
        m_ti = '0; m_tp = '0; m_tb1 = '0; m_tb2 = '0; m_time = '0; m_upd = 1'b0; m_err = 0;
    endtask

    task automatic check_outputs();
        check("freq",       cmd_if.FREQ,            m_freq);
        check("freq_step",  cmd_if.FREQ_STEP,       m_step);
        check("freq_rate",  cmd_if.FREQ_RATE,       m_rate);
        check("time_start", cmd_if.TIME_START,      m_ts);
        check("n_impulse",  cmd_if.N_impulse,       m_n);
        check("type",       cmd_if.TYPE_impulse,    m_type);
        check("ti",         cmd_if.Interval_Ti,     m_ti);
        check("tp",         cmd_if.Interval_Tp,     m_tp);
        check("tblank1",    cmd_if.Tblank1,         m_tb1);
        check("tblank2",    cmd_if.Tblank2,         m_tb2);
        check("time_init",  cmd_if.TIME_INIT,       m_time);
        check("time_upd",   cmd_if.SYS_TIME_UPDATE, m_upd);
        check("err_cnt",    ERR_CNT,                m_err);
    endtask

    function automatic void push_field(input logic [63:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) frame.push_back(v[8*i +: 8]);
    endfunction

    function automatic logic [7:0] frame_sum(input int upto);
        logic [7:0] s = '0;
        for (int i = 0; i < upto; i++) s = s + frame[i];
        return s;
    endfunction

    function automatic void build_cmd(input logic [63:0] f, input logic [63:0] fs, input logic [63:0] rate,
                                      input logic [63:0] ts, input logic [63:0] n, input logic [63:0] typ,
                                      input logic [63:0] ti, input logic [63:0] tp,
                                      input logic [63:0] tb1, input logic [63:0] tb2);
        frame.delete();
        frame.push_back(8'hA1);
        push_field(f, 6);  push_field(fs, 6); push_field(rate, 4); push_field(ts, 8);
        push_field(n, 2);  push_field(typ, 1); push_field(ti, 4);  push_field(tp, 4);
        push_field(tb1, 4); push_field(tb2, 4);
        frame.push_back(frame_sum(frame.size()));
    endfunction

    function automatic void build_cmd_random();
        build_cmd({$urandom, $urandom}, {$urandom, $urandom}, 64'($urandom), {$urandom, $urandom},
                  64'($urandom), 64'($urandom), 64'($urandom), 64'($urandom), 64'($urandom), 64'($urandom));
    endfunction

    function automatic void build_time(input logic [63:0] t);
        frame.delete();
        frame.push_back(8'hA2);
        push_field(t, 8);
        frame.push_back(frame_sum(frame.size()));
    endfunction

    function automatic logic [63:0] field(input int off, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(frame[off + i]);
        return v;
    endfunction

    // A frame commits only if it is complete bytes, of the exact length for its header, with a matching sum.
    function automatic kind_t classify(input int partial_bits);
        int n = frame.size();
        if (partial_bits != 0 || n == 0) return K_BAD;
        if (!((frame[0] == 8'hA1 && n == 45) || (frame[0] == 8'hA2 && n == 10))) return K_BAD;
        if (frame_sum(n - 1) != frame[n - 1]) return K_BAD;
        return (frame[0] == 8'hA1) ? K_CMD : K_TIME;
    endfunction

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int j = 7; j > 7 - nbits; j--) begin
            MOSI = b[j];
            repeat (4) @(negedge CLK);
            SCK = 1'b1;
            repeat (4) @(negedge CLK);
            SCK = 1'b0;
        end
    endtask

    // ok_edge: CLK edge after the CS_n sample edge k at which SYS_TIME_UPDATE_OK is high (-1: none).
    task automatic run_frame(input int partial_bits, input logic [7:0] partial_val,
                             input int rst_at, input int ok_edge);
        int    wr_pos = 0, wr_cnt = 0, err_pos = 0, err_cnt = 0;
        kind_t kind;
        @(negedge CLK);
        CS_n = 1'b0;
        repeat (4) @(negedge CLK);
        for (int i = 0; i < frame.size(); i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(negedge CLK);
                rst_n = 1'b1;
            end
            send_bits(frame[i], 8);
        end
        if (partial_bits > 0) send_bits(partial_val, partial_bits);
        repeat (4) @(negedge CLK);
        CS_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cmd_if.SYS_TIME_UPDATE_OK = (ok_edge >= 0 && c == ok_edge + 1);
            @(negedge CLK);
            if (cmd_if.SPI_WR) begin wr_cnt++;  if (wr_pos == 0)  wr_pos = c;  end
            if (FRAME_ERR)     begin err_cnt++; if (err_pos == 0) err_pos = c; end
        end
        cmd_if.SYS_TIME_UPDATE_OK = 1'b0;

        if (rst_at >= 0 && rst_at < frame.size()) begin
            model_reset();
            kind = K_NONE;
        end else begin
            kind = classify(partial_bits);
        end
        case (kind)
            K_CMD: begin
                m_freq = field(1, 6);  m_step = field(7, 6);  m_rate = field(13, 4);
                m_ts   = field(17, 8); m_n    = field(25, 2); m_type = frame[27][1:0];
                m_ti   = field(28, 4); m_tp   = field(32, 4); m_tb1  = field(36, 4);
                m_tb2  = field(40, 4);
            end
            K_TIME: m_time = field(1, 8);
            K_BAD:  if (m_err < 255) m_err++;
            default: ;
        endcase
        if (kind == K_TIME)    m_upd = (ok_edge > 4) ? 1'b0 : 1'b1;
        else if (ok_edge >= 0) m_upd = 1'b0;

        check("wr_pos",    wr_pos,  (kind == K_CMD) ? 5 : 0);
        check("wr_pulses", wr_cnt,  (kind == K_CMD) ? 1 : 0);
        check("err_pos",   err_pos, (kind == K_BAD) ? 5 : 0);
        check("err_pulses", err_cnt, (kind == K_BAD) ? 1 : 0);
        check_outputs();
    endtask

    task automatic pulse_ok();
        @(negedge CLK);
        cmd_if.SYS_TIME_UPDATE_OK = 1'b1;
        @(negedge CLK);
        cmd_if.SYS_TIME_UPDATE_OK = 1'b0;
        @(negedge CLK);
        m_upd = 1'b0;
    endtask

    initial begin
        int         kind_sel;
        int         ok_sel;
        int         ok_edge;
        logic [7:0] h;

        rst_n = 1'b0; CS_n = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        cmd_if.SYS_TIME_UPDATE_OK = 1'b0;
        model_reset();
        repeat (5) @(negedge CLK);
        check_outputs();
        check("frame_err_rst", FRAME_ERR, 1'b0);
        check("spi_wr_rst", cmd_if.SPI_WR, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge CLK);
        check_outputs();

        // Reference command frame, then the same frame with a corrupted checksum.
        build_cmd(64'h001000000000, 64'h000000100000, 64'h100, 64'h12C0, 64'd2, 64'd1,
                  64'h1800, 64'h1800, 64'h180, 64'h180);
        run_frame(0, 8'h00, -1, -1);
        frame[frame.size() - 1] = frame[frame.size() - 1] + 8'd1;
        run_frame(0, 8'h00, -1, -1);

        // Time presets: overwrite while pending, hold until OK, then a commit coincident with OK.
        build_time(64'h55);
        run_frame(0, 8'h00, -1, -1);
        build_time(64'h0);
        run_frame(0, 8'h00, -1, -1);
        repeat (100) @(negedge CLK);
        check("upd_held", cmd_if.SYS_TIME_UPDATE, 1'b1);
        pulse_ok();
        check("upd_cleared", cmd_if.SYS_TIME_UPDATE, m_upd);
        build_time({$urandom, $urandom});
        run_frame(0, 8'h00, -1, 4);

        // Bad header, partial byte, over-long frame.
        frame.delete();
        frame.push_back(8'h33); frame.push_back(8'($urandom)); frame.push_back(8'($urandom));
        run_frame(0, 8'h00, -1, -1);
        frame.delete();
        frame.push_back(8'hA1); frame.push_back(8'($urandom)); frame.push_back(8'($urandom));
        run_frame(5, 8'($urandom), -1, -1);
        build_cmd_random();
        frame.push_back(8'($urandom));
        run_frame(0, 8'h00, -1, -1);

        // Reset in the middle of a frame, then a clean frame.
        build_cmd_random();
        run_frame(0, 8'h00, 20, -1);
        build_cmd_random();
        run_frame(0, 8'h00, -1, -1);

        for (int r = 0; r < 16; r++) begin
            kind_sel = $urandom_range(0, 6);
            ok_sel   = $urandom_range(0, 4);
            ok_edge  = (ok_sel == 2) ? 2 : (ok_sel == 3) ? 4 : (ok_sel == 4) ? 6 : -1;
            case (kind_sel)
                0, 1: begin build_cmd_random(); run_frame(0, 8'h00, -1, ok_edge); end
                2: begin build_time({$urandom, $urandom}); run_frame(0, 8'h00, -1, ok_edge); end
                3: begin
                    if ($urandom_range(0, 1) == 1) build_cmd_random();
                    else build_time({$urandom, $urandom});
                    frame[frame.size() - 1] = frame[frame.size() - 1] + 8'(1 + $urandom_range(0, 254));
                    run_frame(0, 8'h00, -1, ok_edge);
                end
                4: begin
                    build_cmd_random();
                    h = 8'($urandom);
                    if (h == 8'hA1 || h == 8'hA2) h = 8'h33;
                    frame[0] = h;
                    run_frame(0, 8'h00, -1, ok_edge);
                end
                5: begin
                    build_cmd_random();
                    for (int d = $urandom_range(1, 44); d > 0; d--) void'(frame.pop_back());
                    run_frame(0, 8'h00, -1, ok_edge);
                end
                default: begin
                    build_time({$urandom, $urandom});
                    run_frame($urandom_range(1, 7), 8'($urandom), -1, ok_edge);
                end
            endcase
        end

        // Enough rejected frames to saturate the error counter.
        frame.delete();
        frame.push_back(8'h00);
        for (int r = 0; r < 260; r++) run_frame(0, 8'h00, -1, -1);
        check("err_cnt_sat", ERR_CNT, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
